// File: rtl/backtrack_sequencer.sv
// Records joystick samples into a circular buffer and replays them newest-first after a bumper hit.
// Define BACKTRACK_MIRROR_EN to mirror replayed samples about CENTER.
module backtrack_sequencer #(
   parameter int DEPTH   = 16,
   parameter int CENTER  = 1024,
   parameter int HOLDOFF = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ce,
   input  logic                     x_bumper,
   input  logic                     y_bumper,
   input  logic [10:0]              x_val,
   input  logic [10:0]              y_val,
   output logic [10:0]              x_val_out,
   output logic [10:0]              y_val_out,
   output logic                     backtrack_active,
   output logic [$clog2(DEPTH):0]   fill_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int HW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

`ifdef BACKTRACK_MIRROR_EN
   localparam bit MIRROR_EN = 1'b1;
`else
   localparam bit MIRROR_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_RECORD,
      S_REPLAY,
      S_COOLDOWN
   } state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   wptr_q, wptr_d;
   logic [AW:0]     count_q, count_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic            bump_q, bump_d;
   logic            first_q, first_d;
   logic            active_q, active_d;
   logic [10:0]     x_out_q, x_out_d;
   logic [10:0]     y_out_q, y_out_d;

   logic [21:0]     mem_q [DEPTH];
   logic            mem_we;
   logic [AW-1:0]   rd_idx;
   logic            hit;

   // Mirror about CENTER with saturation into the 11-bit servo range.
   function automatic logic [10:0] replay_xform(input logic [10:0] v);
      int m;
      if (!MIRROR_EN) return v;
      m = 2 * CENTER - int'(v);
      if (m < 0)    return 11'd0;
      if (m > 2047) return 11'd2047;
      return 11'(m);
   endfunction

   assign hit    = (x_bumper | y_bumper) & ~bump_q;
   assign rd_idx = wptr_q - AW'(1);

   always_comb begin
      // NOTE: every signal gets a default here so no path can infer a latch.
      state_d  = state_q;
      wptr_d   = wptr_q;
      count_d  = count_q;
      hold_d   = hold_q;
      bump_d   = x_bumper | y_bumper;
      first_d  = 1'b0;
      x_out_d  = x_val;
      y_out_d  = y_val;
      mem_we   = 1'b0;

      unique case (state_q)
         S_RECORD: begin
            if (hit) begin
               if (count_q != '0) begin
                  state_d = S_REPLAY;
                  first_d = 1'b1;
               end else begin
                  state_d = S_COOLDOWN;
                  hold_d  = HW'(HOLDOFF);
               end
            end else if (ce) begin
               mem_we = 1'b1;
               wptr_d = wptr_q + AW'(1);
               if (count_q != (AW+1)'(DEPTH)) count_d = count_q + (AW+1)'(1);
            end
         end
         S_REPLAY: begin
            x_out_d = x_out_q;
            y_out_d = y_out_q;
            if (first_q || (ce && count_q != '0)) begin
               wptr_d  = rd_idx;
               count_d = count_q - (AW+1)'(1);
               x_out_d = replay_xform(mem_q[rd_idx][21:11]);
               y_out_d = replay_xform(mem_q[rd_idx][10:0]);
            end else if (ce) begin
               state_d = S_COOLDOWN;
               hold_d  = HW'(HOLDOFF);
            end
         end
         S_COOLDOWN: begin
            if (ce) begin
               if (hold_q <= HW'(1)) begin
                  state_d = S_RECORD;
                  count_d = '0;
                  hold_d  = '0;
               end else begin
                  hold_d = hold_q - HW'(1);
               end
            end
         end
         default: state_d = S_RECORD;
      endcase

      active_d = (state_d == S_REPLAY);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_RECORD;
         wptr_q   <= '0;
         count_q  <= '0;
         hold_q   <= '0;
         bump_q   <= 1'b0;
         first_q  <= 1'b0;
         active_q <= 1'b0;
         x_out_q  <= '0;
         y_out_q  <= '0;
      end else begin
         state_q  <= state_d;
         wptr_q   <= wptr_d;
         count_q  <= count_d;
         hold_q   <= hold_d;
         bump_q   <= bump_d;
         first_q  <= first_d;
         active_q <= active_d;
         x_out_q  <= x_out_d;
         y_out_q  <= y_out_d;
      end
   end

   // NOTE: the sample buffer is deliberately not reset; count_q == 0 marks it empty.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[wptr_q] <= {x_val, y_val};
   end

   assign x_val_out        = x_out_q;
   assign y_val_out        = y_out_q;
   assign backtrack_active = active_q;
   assign fill_level       = count_q;

endmodule

// File: tb/tb_backtrack_sequencer.sv
// Self-checking bench for backtrack_sequencer against a queue-based behavioural model.
module tb_backtrack_sequencer;

   localparam int DEPTH   = 16;
   localparam int CENTER  = 1024;
   localparam int HOLDOFF = 5;

`ifdef BACKTRACK_MIRROR_EN
   localparam bit TB_MIR = 1'b1;
`else
   localparam bit TB_MIR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        ce;
   logic        x_bumper;
   logic        y_bumper;
   logic [10:0] x_val;
   logic [10:0] y_val;
   logic [10:0] x_val_out;
   logic [10:0] y_val_out;
   logic        backtrack_active;
   logic [$clog2(DEPTH):0] fill_level;

   int tests = 0;
   int fails = 0;
   int cycle = 0;

   backtrack_sequencer #(.DEPTH(DEPTH), .CENTER(CENTER), .HOLDOFF(HOLDOFF)) dut (
      .clk              (clk),
      .rst              (rst),
      .ce               (ce),
      .x_bumper         (x_bumper),
      .y_bumper         (y_bumper),
      .x_val            (x_val),
      .y_val            (y_val),
      .x_val_out        (x_val_out),
      .y_val_out        (y_val_out),
      .backtrack_active (backtrack_active),
      .fill_level       (fill_level)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // Behavioural model: a bounded history queue plus a mode, cooldown measured in elapsed ticks.
   typedef enum {M_REC, M_REP, M_COOL} mode_e;
   mode_e       m_mode = M_REC;
   logic [21:0] m_q[$];
   bit          m_hist = 1'b0;
   bit          m_first = 1'b0;
   int          m_cool_ticks = 0;
   logic [10:0] m_x = '0;
   logic [10:0] m_y = '0;

   function automatic logic [10:0] m_mirror(input logic [10:0] v);
      int r;
      if (!TB_MIR) return v;
      r = 2 * CENTER - int'(v);
      if (r < 0) r = 0;
      if (r > 2047) r = 2047;
      return 11'(r);
   endfunction

   function automatic logic [10:0] rnd();
      return 11'($urandom_range(0, 2047));
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cycle, obs, exp);
      end
   endtask

   task automatic model_update(input bit r, input bit c, input bit xb, input bit yb,
                               input logic [10:0] xv, input logic [10:0] yv);
      bit          h;
      logic [21:0] s;
      if (!r) begin
         m_mode = M_REC;
         m_q.delete();
         m_hist = 1'b0;
         m_first = 1'b0;
         m_cool_ticks = 0;
         m_x = '0;
         m_y = '0;
         return;
      end
      h = (xb || yb) && !m_hist;
      m_hist = xb || yb;
      case (m_mode)
         M_REC: begin
            m_x = xv;
            m_y = yv;
            if (h) begin
               if (m_q.size() > 0) begin
                  m_mode = M_REP;
                  m_first = 1'b1;
               end else begin
                  m_mode = M_COOL;
                  m_cool_ticks = 0;
               end
            end else if (c) begin
               m_q.push_back({xv, yv});
               if (m_q.size() > DEPTH) void'(m_q.pop_front());
            end
         end
         M_REP: begin
            if (m_first || (c && m_q.size() > 0)) begin
               s = m_q.pop_back();
               m_x = m_mirror(s[21:11]);
               m_y = m_mirror(s[10:0]);
            end else if (c) begin
               m_mode = M_COOL;
               m_cool_ticks = 0;
            end
            m_first = 1'b0;
         end
         M_COOL: begin
            m_x = xv;
            m_y = yv;
            if (c) begin
               m_cool_ticks++;
               if (m_cool_ticks >= HOLDOFF) m_mode = M_REC;
            end
         end
         default: m_mode = M_REC;
      endcase
   endtask

   task automatic step(input bit r, input bit c, input bit xb, input bit yb,
                       input logic [10:0] xv, input logic [10:0] yv);
      rst = r;
      ce = c;
      x_bumper = xb;
      y_bumper = yb;
      x_val = xv;
      y_val = yv;
      @(posedge clk);
      cycle++;
      model_update(r, c, xb, yb, xv, yv);
      #1;
      check("x_val_out", 32'(x_val_out), 32'(m_x));
      check("y_val_out", 32'(y_val_out), 32'(m_y));
      check("backtrack_active", 32'(backtrack_active), 32'(m_mode == M_REP));
      check("fill_level", 32'(fill_level), 32'(m_q.size()));
   endtask

   // Runs replay/cooldown to completion; noisy mode holds x_bumper and toggles y_bumper.
   task automatic run_until_record(input int budget, input bit noisy);
      int n = 0;
      while (m_mode != M_REC) begin
         if (n >= budget) begin
            fails++;
            $display("FAIL run_until_record: observed no return to RECORD after %0d cycles, expected return", budget);
            break;
         end
         step(1'b1, (n % 3) == 2, noisy, noisy & n[0], rnd(), rnd());
         n++;
      end
      step(1'b1, 1'b0, 1'b0, 1'b0, rnd(), rnd());
   endtask

   initial begin
      bit bx = 1'b0;
      bit by = 1'b0;
      rst = 1'b0;
      ce = 1'b0;
      x_bumper = 1'b0;
      y_bumper = 1'b0;
      x_val = '0;
      y_val = '0;
      @(negedge clk);

      // Reset held with ce toggling, then outputs follow inputs one cycle late.
      for (int i = 0; i < 3; i++) step(1'b0, i[0], 1'b0, 1'b0, rnd(), rnd());
      check("reset_x_zero", 32'(x_val_out), 32'd0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, rnd(), rnd());

      // Record three samples, hit, replay newest first.
      step(1'b1, 1'b1, 1'b0, 1'b0, 11'd100, 11'd500);
      step(1'b1, 1'b0, 1'b0, 1'b0, rnd(), rnd());
      step(1'b1, 1'b1, 1'b0, 1'b0, 11'd200, 11'd600);
      step(1'b1, 1'b0, 1'b0, 1'b0, rnd(), rnd());
      step(1'b1, 1'b1, 1'b0, 1'b0, 11'd300, 11'd700);
      step(1'b1, 1'b0, 1'b1, 1'b0, rnd(), rnd());
      check("active_after_hit", 32'(backtrack_active), 32'd1);
      step(1'b1, 1'b0, 1'b0, 1'b0, rnd(), rnd());
      check("first_pop_x", 32'(x_val_out), TB_MIR ? 32'd1748 : 32'd300);
      check("first_pop_y", 32'(y_val_out), TB_MIR ? 32'd1348 : 32'd700);
      run_until_record(200, 1'b0);

      // Hit coinciding with ce must not store the sample.
      step(1'b1, 1'b1, 1'b0, 1'b0, 11'd11, 11'd22);
      step(1'b1, 1'b1, 1'b0, 1'b0, 11'd33, 11'd44);
      step(1'b1, 1'b1, 1'b1, 1'b0, 11'd55, 11'd66);
      check("hit_ce_fill", 32'(fill_level), 32'd2);
      step(1'b1, 1'b0, 1'b0, 1'b0, rnd(), rnd());
      check("hit_ce_pop_x", 32'(x_val_out), TB_MIR ? 32'd2015 : 32'd33);
      run_until_record(200, 1'b0);

      // Hit on an empty buffer goes straight to cooldown.
      step(1'b1, 1'b0, 1'b0, 1'b1, rnd(), rnd());
      check("empty_hit_inactive", 32'(backtrack_active), 32'd0);
      run_until_record(200, 1'b0);

      // Wrap: 20 pushes into 16 slots, replay 20 down to 5 with bumper noise ignored.
      for (int i = 1; i <= 20; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 11'(i), rnd());
      check("wrap_fill", 32'(fill_level), 32'd16);
      step(1'b1, 1'b0, 1'b1, 1'b0, rnd(), rnd());
      step(1'b1, 1'b0, 1'b1, 1'b1, rnd(), rnd());
      check("wrap_first_x", 32'(x_val_out), TB_MIR ? 32'd2028 : 32'd20);
      run_until_record(400, 1'b1);

      // Reset in the middle of a replay.
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, rnd(), rnd());
      step(1'b1, 1'b0, 1'b1, 1'b0, rnd(), rnd());
      step(1'b1, 1'b0, 1'b0, 1'b0, rnd(), rnd());
      step(1'b1, 1'b1, 1'b0, 1'b0, rnd(), rnd());
      step(1'b0, 1'b1, 1'b0, 1'b0, rnd(), rnd());
      check("midreplay_rst_x", 32'(x_val_out), 32'd0);
      check("midreplay_rst_fill", 32'(fill_level), 32'd0);
      step(1'b1, 1'b0, 1'b0, 1'b0, rnd(), rnd());

      // Randomised traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 11) == 0) bx = ~bx;
         if ($urandom_range(0, 11) == 0) by = ~by;
         step($urandom_range(0, 299) != 0, $urandom_range(0, 2) == 0, bx, by, rnd(), rnd());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
